// File: rtl/auction_pkg.sv
// Shared types and helpers for the sealed-bid second-price auction engine.
package auction_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StResult
  } state_e;

  // Bidder index width. Clamped to at least one bit so the index ports stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/auction_top2_update.sv
// Combinational update of the running top-two bid tracker with one new bid.
// Strictly higher values win; equal values go to the lower bidder index, and
// the displaced leader becomes the runner-up.
module auction_top2_update
  import auction_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned IDXW = 2
) (
  input  logic [2*W+IDXW-1:0] cur,
  input  logic [IDXW-1:0]     id,
  input  logic [W-1:0]        value,
  output logic [2*W+IDXW-1:0] nxt
);

  typedef struct packed {
    logic [W-1:0]    max1;
    logic [W-1:0]    max2;
    logic [IDXW-1:0] id1;
  } top2_t;

  top2_t c;
  top2_t n;

  // Insert the new bid into the leader / runner-up pair.
  always_comb begin
    c = cur;
    n = c;
    if ((value > c.max1) || ((value == c.max1) && (id < c.id1))) begin
      n.max2 = c.max1;
      n.max1 = value;
      n.id1  = id;
    end else if (value > c.max2) begin
      n.max2 = value;
    end
    nxt = n;
  end

endmodule

// File: rtl/auction_vickrey_seq.sv
// Sequential N-bidder Vickrey auction: collects streamed bids, tracks the top
// two, then presents winner and second price on a held valid/ready result port.
module auction_vickrey_seq
  import auction_pkg::*;
#(
  parameter int unsigned  N    = 4,
  parameter int unsigned  W    = 16,
  localparam int unsigned IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            close,
  input  logic            bid_valid,
  output logic            bid_ready,
  input  logic [IDXW-1:0] bid_id,
  input  logic [W-1:0]    bid_value,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IDXW-1:0] res_winner,
  output logic [W-1:0]    res_price,
  output logic            res_nobid,
  output logic            res_err,
  output logic            busy
);

  typedef struct packed {
    logic [W-1:0]    max1;
    logic [W-1:0]    max2;
    logic [IDXW-1:0] id1;
  } top2_t;

  localparam logic [IDXW:0] NumIds = (IDXW + 1)'(N);

  state_e       state_q;
  top2_t        top2_q;
  top2_t        top2_upd;
  top2_t        top2_nxt;
  logic [N-1:0] seen_q;
  logic [N-1:0] seen_nxt;
  logic         err_q;
  logic         err_nxt;
  logic         accept;
  logic         in_range;
  logic         dup;
  logic         take;
  logic         done;

  auction_top2_update #(
    .W    (W),
    .IDXW (IDXW)
  ) u_top2 (
    .cur   (top2_q),
    .id    (bid_id),
    .value (bid_value),
    .nxt   (top2_upd)
  );

  assign bid_ready = (state_q == StCollect);
  assign res_valid = (state_q == StResult);
  assign busy      = (state_q != StIdle);

  // Classify the incoming bid and form next-state collection values.
  always_comb begin
    accept   = bid_valid && bid_ready;
    in_range = ({1'b0, bid_id} < NumIds);
    // in_range gates the mask lookup so an out-of-range index is never used
    dup      = in_range && seen_q[bid_id];
    take     = accept && in_range && !dup;
    seen_nxt = seen_q;
    if (take) begin
      seen_nxt[bid_id] = 1'b1;
    end
    top2_nxt = take ? top2_upd : top2_q;
    err_nxt  = err_q | (accept && !take);
    // A bid arriving with close is folded in before the auction ends
    done     = (state_q == StCollect) && ((take && (&seen_nxt)) || close);
  end

  // Auction FSM with collection state and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      top2_q     <= '0;
      seen_q     <= '0;
      err_q      <= 1'b0;
      res_winner <= '0;
      res_price  <= '0;
      res_nobid  <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StCollect;
            top2_q  <= '0;
            seen_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        StCollect: begin
          top2_q <= top2_nxt;
          seen_q <= seen_nxt;
          err_q  <= err_nxt;
          if (done) begin
            state_q <= StResult;
            // With no nonzero bid there is no real winner; report index 0, price 0
            if (top2_nxt.max1 == '0) begin
              res_winner <= '0;
              res_price  <= '0;
              res_nobid  <= 1'b1;
            end else begin
              res_winner <= top2_nxt.id1;
              res_price  <= top2_nxt.max2;
              res_nobid  <= 1'b0;
            end
            res_err <= err_nxt;
          end
        end
        StResult: begin
          if (res_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_auction_vickrey_seq.sv
// Directed testbench for auction_vickrey_seq (N=4 main instance, N=3 for range checks).
module tb_auction_vickrey_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        close     = 1'b0;
  logic        bid_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [1:0]  bid_id    = '0;
  logic [15:0] bid_value = '0;

  logic        bid_ready, res_valid, busy, res_nobid, res_err;
  logic [1:0]  res_winner;
  logic [15:0] res_price;

  logic        bid_ready3, res_valid3, busy3, res_nobid3, res_err3;
  logic [1:0]  res_winner3;
  logic [15:0] res_price3;

  int total = 0;
  int bad   = 0;

  auction_vickrey_seq #(.N(4), .W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .close      (close),
    .bid_valid  (bid_valid),
    .bid_ready  (bid_ready),
    .bid_id     (bid_id),
    .bid_value  (bid_value),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_winner (res_winner),
    .res_price  (res_price),
    .res_nobid  (res_nobid),
    .res_err    (res_err),
    .busy       (busy)
  );

  auction_vickrey_seq #(.N(3), .W(16)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .close      (close),
    .bid_valid  (bid_valid),
    .bid_ready  (bid_ready3),
    .bid_id     (bid_id),
    .bid_value  (bid_value),
    .res_valid  (res_valid3),
    .res_ready  (res_ready),
    .res_winner (res_winner3),
    .res_price  (res_price3),
    .res_nobid  (res_nobid3),
    .res_err    (res_err3),
    .busy       (busy3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic bid(input logic [1:0] id, input logic [15:0] v);
    bid_valid = 1'b1;
    bid_id    = id;
    bid_value = v;
    step();
    bid_valid = 1'b0;
  endtask

  task automatic bid_close(input logic [1:0] id, input logic [15:0] v);
    close = 1'b1;
    bid(id, v);
    close = 1'b0;
  endtask

  task automatic do_close();
    close = 1'b1;
    step();
    close = 1'b0;
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bid_ready, res_valid, busy, res_nobid, res_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bid_ready, res_valid, busy, res_nobid, res_err});
    end
    total++;
    if (res_winner !== 2'd0 || res_price !== 16'd0) begin
      bad++;
      $display("FAIL reset_result got w=%0d p=%0d want w=0 p=0", res_winner, res_price);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_start();
    bid(2'd0, 16'd100);
    bid(2'd1, 16'd250);
    bid(2'd2, 16'd40);
    total++;
    if (res_valid !== 1'b0 || bid_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_collecting got valid=%b ready=%b want valid=0 ready=1",
               res_valid, bid_ready);
    end
    bid(2'd3, 16'd180);
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd1, 16'd180, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=1 p=180 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    total++;
    if (bid_ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_result_flags got ready=%b busy=%b want ready=0 busy=1",
               bid_ready, busy);
    end
    release_result();
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got busy=%b valid=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_tie();
    do_start();
    bid(2'd3, 16'd500);
    bid(2'd0, 16'd500);
    bid(2'd1, 16'd7);
    bid(2'd2, 16'd7);
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd0, 16'd500, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL tie_result got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=0 p=500 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  task automatic test_early_close();
    do_start();
    bid(2'd2, 16'd9);
    do_close();
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd2, 16'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL early_close got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=2 p=0 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  task automatic test_all_zero();
    do_start();
    for (int i = 0; i < 4; i++) begin
      bid(2'(i), 16'd0);
    end
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd0, 16'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL all_zero got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=0 p=0 n=1 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  task automatic test_duplicate();
    do_start();
    bid(2'd1, 16'd300);
    bid(2'd1, 16'd900);
    bid_close(2'd0, 16'd10);
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd1, 16'd10, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL duplicate got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=1 p=10 n=0 e=1",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  task automatic test_out_of_range();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start();
    bid(2'd3, 16'd999);
    bid(2'd0, 16'd5);
    bid(2'd1, 16'd6);
    total++;
    if (res_valid3 !== 1'b0) begin
      bad++;
      $display("FAIL range_no_early_done got valid=%b want 0", res_valid3);
    end
    bid(2'd2, 16'd7);
    total++;
    if ({res_valid3, res_winner3, res_price3, res_nobid3, res_err3} !==
        {1'b1, 2'd2, 16'd6, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL range_result got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=2 p=6 n=0 e=1",
               res_valid3, res_winner3, res_price3, res_nobid3, res_err3);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    do_start();
    bid(2'd0, 16'd1);
    bid(2'd1, 16'd2);
    bid(2'd2, 16'd3);
    bid(2'd3, 16'd4);
    start     = 1'b1;
    bid_valid = 1'b1;
    bid_id    = 2'd0;
    bid_value = 16'd60000;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({res_valid, bid_ready, res_winner, res_price, res_nobid, res_err} !==
          {1'b1, 1'b0, 2'd3, 16'd3, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b w=%0d p=%0d want v=1 r=0 w=3 p=3",
                 i, res_valid, bid_ready, res_winner, res_price);
      end
    end
    start     = 1'b0;
    bid_valid = 1'b0;
    release_result();
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    do_start();
    bid(2'd2, 16'd50);
    do_close();
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd2, 16'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL backpressure_clean got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=2 p=0 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    do_start();
    bid(2'd1, 16'd800);
    bid(2'd2, 16'd1);
    rst_n = 1'b0;
    #2;
    total++;
    if ({bid_ready, res_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_collect got ready/valid/busy=%b want 000",
               {bid_ready, res_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start();
    bid(2'd0, 16'd5);
    do_close();
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd0, 16'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_collect_next got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=0 p=0 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();

    do_start();
    bid(2'd3, 16'd70);
    bid(2'd3, 16'd1);
    do_close();
    total++;
    if ({res_valid, res_winner, res_err} !== {1'b1, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_result_pre got v=%b w=%0d e=%b want v=1 w=3 e=1",
               res_valid, res_winner, res_err);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if ({res_valid, busy, res_winner, res_price, res_nobid, res_err} !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_result got v=%b b=%b w=%0d p=%0d n=%b e=%b want all 0",
               res_valid, busy, res_winner, res_price, res_nobid, res_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start();
    bid(2'd1, 16'd3);
    bid(2'd0, 16'd3);
    do_close();
    total++;
    if ({res_valid, res_winner, res_price, res_nobid, res_err} !==
        {1'b1, 2'd0, 16'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_result_next got v=%b w=%0d p=%0d n=%b e=%b want v=1 w=0 p=3 n=0 e=0",
               res_valid, res_winner, res_price, res_nobid, res_err);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_early_close();
    test_all_zero();
    test_duplicate();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
